// File: rtl/mux_4to1.sv
// ============================================================================
// Module   : mux_4to1
// Purpose  : 4-lane multiplexer with a combinational output and a registered,
//            enable-qualified copy (value, select and valid flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4to1 #(
    parameter int WIDTH           = 1,
    parameter bit HOLD_ON_DISABLE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] in,
    input  logic [1:0]         sel,
    input  logic               en,
    output logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   y_q,
    output logic               y_q_valid,
    output logic [1:0]         sel_q
);

    logic [WIDTH-1:0] w_lane [4];
    logic [WIDTH-1:0] w_y;

    logic [WIDTH-1:0] r_y_q;
    logic [1:0]       r_sel_q;
    logic             r_valid;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_lane[k] = in[k*WIDTH +: WIDTH];
    end

    // A single case over sel avoids transient selection of other lanes and
    // drives all-X when sel is unknown, independent of unselected lane contents.
    always_comb begin
        w_y = '0;
        case (sel)
            2'b00:   w_y = w_lane[0];
            2'b01:   w_y = w_lane[1];
            2'b10:   w_y = w_lane[2];
            2'b11:   w_y = w_lane[3];
            default: w_y = {WIDTH{1'bx}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q   <= '0;
            r_sel_q <= 2'b00;
            r_valid <= 1'b0;
        end else if (en) begin
            r_y_q   <= w_y;
            r_sel_q <= sel;
            r_valid <= 1'b1;
        end else if (!HOLD_ON_DISABLE) begin
            // sel_q deliberately keeps the last select in clear mode
            r_y_q   <= '0;
            r_valid <= 1'b0;
        end
    end

    assign y         = w_y;
    assign y_q       = r_y_q;
    assign sel_q     = r_sel_q;
    assign y_q_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_4to1.sv
// ============================================================================
// Module   : tb_mux_4to1
// Purpose  : Directed self-checking bench for mux_4to1 across three configs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_4to1;

    logic clk = 1'b0;
    bit   clk_run = 1'b0;
    logic rst_n = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    // WIDTH=1, hold mode
    logic [3:0]  in1  = '0;
    logic [1:0]  sel1 = '0;
    logic        en1  = 1'b0;
    logic        y1, yq1, v1;
    logic [1:0]  sq1;

    // WIDTH=8, hold mode
    logic [31:0] in8  = '0;
    logic [1:0]  sel8 = '0;
    logic        en8  = 1'b0;
    logic [7:0]  y8, yq8;
    logic        v8;
    logic [1:0]  sq8;

    // WIDTH=4, clear mode
    logic [15:0] inz  = '0;
    logic [1:0]  selz = '0;
    logic        enz  = 1'b0;
    logic [3:0]  yz, yqz;
    logic        vz;
    logic [1:0]  sqz;

    mux_4to1 #(.WIDTH(1), .HOLD_ON_DISABLE(1'b1)) d1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1), .en(en1),
        .y(y1), .y_q(yq1), .y_q_valid(v1), .sel_q(sq1)
    );

    mux_4to1 #(.WIDTH(8), .HOLD_ON_DISABLE(1'b1)) d8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .en(en8),
        .y(y8), .y_q(yq8), .y_q_valid(v8), .sel_q(sq8)
    );

    mux_4to1 #(.WIDTH(4), .HOLD_ON_DISABLE(1'b0)) dz (
        .clk(clk), .rst_n(rst_n), .in(inz), .sel(selz), .en(enz),
        .y(yz), .y_q(yqz), .y_q_valid(vz), .sel_q(sqz)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, no clock running
        #1;
        check("rst_yq",    32'(yq1), 32'h0);
        check("rst_selq",  32'(sq1), 32'h0);
        check("rst_valid", 32'(v1),  32'h0);

        // Combinational sweep with clock idle and reset held
        in1 = 4'b1010;
        sel1 = 2'b00; #10; check("sweepA_s0", 32'(y1), 32'h0);
        sel1 = 2'b01; #10; check("sweepA_s1", 32'(y1), 32'h1);
        sel1 = 2'b10; #10; check("sweepA_s2", 32'(y1), 32'h0);
        sel1 = 2'b11; #10; check("sweepA_s3", 32'(y1), 32'h1);

        in1 = 4'b0110;
        sel1 = 2'b00; #1; check("sweepB_s0", 32'(y1), 32'h0);
        sel1 = 2'b01; #1; check("sweepB_s1", 32'(y1), 32'h1);
        sel1 = 2'b10; #1; check("sweepB_s2", 32'(y1), 32'h1);
        sel1 = 2'b11; #1; check("sweepB_s3", 32'(y1), 32'h0);
        in1 = 4'b1001; #0; check("same_step", 32'(y1), 32'h1);

        // Clock runs while reset is held: registered outputs stay cleared
        en1 = 1'b1; en8 = 1'b1; enz = 1'b1;
        clk_run = 1'b1;
        tick();
        tick();
        check("rst_hold_yq",    32'(yq1), 32'h0);
        check("rst_hold_valid", 32'(v1),  32'h0);

        // Release reset and capture lane 1
        rst_n = 1'b1;
        in1 = 4'b1010; sel1 = 2'b01;
        in8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; sel8 = 2'b10;
        inz = 16'h4321; selz = 2'b10;
        #1;
        check("w8_comb", 32'(y8), 32'hCC);
        tick();
        check("cap_yq",    32'(yq1), 32'h1);
        check("cap_selq",  32'(sq1), 32'h1);
        check("cap_valid", 32'(v1),  32'h1);
        check("w8_cap",    32'(yq8), 32'hCC);
        check("w8_selq",   32'(sq8), 32'h2);
        check("clr_cap",   32'(yqz), 32'h3);
        check("clr_capv",  32'(vz),  32'h1);

        // Between-edge changes must not reach the registers
        in8 = {8'h11, 8'h22, 8'h33, 8'h44}; sel8 = 2'b11; #2;
        check("w8_comb_mid", 32'(y8),  32'h11);
        check("w8_no_mid",   32'(yq8), 32'hCC);

        // Hold on disable vs clear on disable
        en1 = 1'b0; sel1 = 2'b00;
        en8 = 1'b0;
        enz = 1'b0; selz = 2'b01;
        tick();
        check("hold_yq",    32'(yq1), 32'h1);
        check("hold_selq",  32'(sq1), 32'h1);
        check("hold_valid", 32'(v1),  32'h1);
        check("hold_y",     32'(y1),  32'h0);
        check("w8_hold",    32'(yq8), 32'hCC);
        check("clr_yq",     32'(yqz), 32'h0);
        check("clr_valid",  32'(vz),  32'h0);
        check("clr_selq",   32'(sqz), 32'h2);

        // Bit mapping for a multi-bit lane
        en8 = 1'b1; sel8 = 2'b01; in8 = {8'h00, 8'h00, 8'h5A, 8'h00};
        tick();
        check("w8_bitmap", 32'(yq8), 32'h5A);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_yq",    32'(yq1), 32'h0);
        check("arst_selq",  32'(sq1), 32'h0);
        check("arst_valid", 32'(v1),  32'h0);
        check("arst_w8",    32'(yq8), 32'h0);
        check("arst_y",     32'(y1),  32'h0);
        sel1 = 2'b11; #1;
        check("arst_y_s3",  32'(y1),  32'h1);

        // First enabled edge after reset release performs a normal capture
        tick();
        rst_n = 1'b1;
        en1 = 1'b1; sel1 = 2'b11;
        tick();
        check("post_rst_yq",    32'(yq1), 32'h1);
        check("post_rst_selq",  32'(sq1), 32'h3);
        check("post_rst_valid", 32'(v1),  32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
